// File: rtl/aes_round_ctrl_pkg.sv
// Shared AES-128 definitions: FSM encoding, round count, Rcon, S-box.
// Imported by the round controller, its datapath and the key step.
package aes_round_ctrl_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  // S-box flattened, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX_TBL[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Rcon for rounds 1..10; other indices yield 0.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: key_in + rcon -> key_out.
// RotWord/SubWord on the last word, then a running XOR across words.
module aes_key_step
  import aes_round_ctrl_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, tmp;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign tmp = {sbox(rot[31:24]), sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon, 24'h0};

  assign n0 = w0 ^ tmp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_out = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_ctrl_ops.sv
// Combinational AES round primitives: SubBytes, ShiftRows, MixColumns,
// AddRoundKey. Ports: d_in[127:0] -> d_out[127:0] (plus rk for ARK).
module aes_sub_bytes
  import aes_round_ctrl_pkg::*;
(
  input  logic [127:0] d_in,
  output logic [127:0] d_out
);
  for (genvar i = 0; i < 16; i++) begin : g_sb
    assign d_out[8*i +: 8] = sbox(d_in[8*i +: 8]);
  end
endmodule

module aes_shift_rows (
  input  logic [127:0] d_in,
  output logic [127:0] d_out
);
  // Byte 4c+r lives at bits [127-8(4c+r) -: 8]; row r rotates left by r.
  always_comb begin
    d_out = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        d_out[127 - 8*(4*c + r) -: 8] =
          d_in[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
  end
endmodule

module aes_mix_columns
  import aes_round_ctrl_pkg::*;
(
  input  logic [127:0] d_in,
  output logic [127:0] d_out
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = d_in[127 - 32*c -: 8];
    assign a1 = d_in[119 - 32*c -: 8];
    assign a2 = d_in[111 - 32*c -: 8];
    assign a3 = d_in[103 - 32*c -: 8];
    assign d_out[127 - 32*c -: 8] =
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign d_out[119 - 32*c -: 8] =
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign d_out[111 - 32*c -: 8] =
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign d_out[103 - 32*c -: 8] =
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end
endmodule

module aes_add_round_key (
  input  logic [127:0] d_in,
  input  logic [127:0] rk,
  output logic [127:0] d_out
);
  assign d_out = d_in ^ rk;
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor, one round per clock, shared datapath.
// Ports: clk, rst, in_valid/in_ready, plaintext, key, out_valid/out_ready,
// ciphertext, busy, round.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy,
  output logic [3:0]   round
);
  fsm_t         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;

  logic [127:0] sb_out, sr_out, mc_out;
  logic [127:0] mix_sel, ark_out, key_next;
  logic         last;

  assign last = (rnd_q == 4'(NR));

  aes_key_step u_ks (
    .key_in  (rk_q),
    .rcon    (rcon(rnd_q)),
    .key_out (key_next)
  );

  aes_sub_bytes u_sb (
    .d_in  (st_q),
    .d_out (sb_out)
  );

  aes_shift_rows u_sr (
    .d_in  (sb_out),
    .d_out (sr_out)
  );

  aes_mix_columns u_mc (
    .d_in  (sr_out),
    .d_out (mc_out)
  );

  // Final round skips MixColumns.
  assign mix_sel = last ? sr_out : mc_out;

  aes_add_round_key u_ark (
    .d_in  (mix_sel),
    .rk    (key_next),
    .d_out (ark_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      rnd_q <= '0;
      st_q  <= '0;
      rk_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q  <= st_d;
      rk_q  <= rk_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d  = st_q;
    rk_d  = rk_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d  = plaintext ^ key;
          rk_d  = key;
          rnd_d = 4'd1;
          fsm_d = S_ROUND;
        end
      end
      S_ROUND: begin
        st_d = ark_out;
        rk_d = key_next;
        if (last) begin
          fsm_d = S_DONE;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          rnd_d = '0;
          fsm_d = S_IDLE;
        end
      end
      default: begin
        rnd_d = '0;
        fsm_d = S_IDLE;
      end
    endcase
  end

  assign in_ready   = (fsm_q == S_IDLE);
  assign out_valid  = (fsm_q == S_DONE);
  assign busy       = (fsm_q != S_IDLE);
  assign ciphertext = st_q;
  assign round      = rnd_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl against a byte-array AES model.
// Covers reset, known vectors, latency, stall, abort, back-to-back, random.
module tb_aes_round_ctrl;

  logic         clk = 0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round)
  );

  // ---------------- reference model ----------------
  logic [7:0] sbm [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // S-box from GF(2^8) inverse plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      sbm[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
               ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt,
                                             input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbm[tmp[31:24]], sbm[tmp[23:16]],
               sbm[tmp[15:8]], sbm[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbm[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++)
          s[4*c + q] = t[4*((c + q) % 4) + q];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
          s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offers one block, waits for out_valid; lat counts edges from the
  // acceptance edge (inclusive), -1 on timeout. Leaves block in DONE.
  task automatic drive_block(input logic [127:0] p, input logic [127:0] k,
                             output logic [127:0] ct, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    plaintext = p;
    key = k;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    ct = ciphertext;
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1;
    in_valid = 1;
    plaintext = rnd128();
    key = rnd128();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    in_valid = 0;
    tests++;
    if ({in_ready, out_valid, busy, round} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++;
      $display("FAIL reset_ctl got rdy=%b ov=%b busy=%b rnd=%0d exp 1 0 0 0",
               in_ready, out_valid, busy, round);
    end
    tests++;
    if (ciphertext !== 128'h0) begin
      fails++;
      $display("FAIL reset_state got %h exp 0", ciphertext);
    end
  endtask

  task automatic test_fips197();
    int lat;
    plaintext = P1;
    key = K1;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    tests++;
    if (round !== 4'd1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL round1_ctl got rnd=%0d busy=%b rdy=%b exp 1 1 0",
               round, busy, in_ready);
    end
    tests++;
    if (dut.sr_out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5) begin
      fails++;
      $display("FAIL mc_in got %h exp d4bf5d30e0b452aeb84111f11e2798e5",
               dut.sr_out);
    end
    tests++;
    if (dut.mc_out !== 128'h046681e5e0cb199a48f8d37a2806264c) begin
      fails++;
      $display("FAIL mc_out got %h exp 046681e5e0cb199a48f8d37a2806264c",
               dut.mc_out);
    end
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (ciphertext !== C1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL fips_ct got %h ov=%b exp %h", ciphertext, out_valid, C1);
    end
    tests++;
    if (round !== 4'd10 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_ctl got rnd=%0d busy=%b exp 10 1", round, busy);
    end
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || round !== 4'd0) begin
      fails++;
      $display("FAIL to_idle got rdy=%b ov=%b rnd=%0d exp 1 0 0",
               in_ready, out_valid, round);
    end
  endtask

  task automatic test_latency();
    logic [127:0] ct;
    int lat;
    drive_block(P2, K2, ct, lat);
    tests++;
    if (lat !== 11) begin
      fails++;
      $display("FAIL latency got %0d exp 11", lat);
    end
    tests++;
    if (ct !== C2) begin
      fails++;
      $display("FAIL c2_ct got %h exp %h", ct, C2);
    end
    release_out();
  endtask

  task automatic test_hold();
    logic [127:0] ct;
    int lat;
    drive_block(P1, K1, ct, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = $urandom_range(0, 1);
      plaintext = rnd128();
      key = rnd128();
      out_ready = 0;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || ciphertext !== C1 || in_ready !== 1'b0
          || round !== 4'd10) begin
        fails++;
        $display("FAIL hold%0d got ov=%b ct=%h rdy=%b rnd=%0d exp 1 %h 0 10",
                 i, out_valid, ciphertext, in_ready, round, C1);
      end
    end
    in_valid = 0;
    release_out();
  endtask

  task automatic test_abort();
    logic [127:0] ct;
    int lat;
    plaintext = P1;
    key = K1;
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    tests++;
    if (round !== 4'd5 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_abort got rnd=%0d busy=%b exp 5 1", round, busy);
    end
    rst = 1;
    out_ready = 1;
    @(posedge clk); #1;
    rst = 0;
    out_ready = 0;
    tests++;
    if ({in_ready, out_valid, busy, round} !== {1'b1, 1'b0, 1'b0, 4'd0}
        || ciphertext !== 128'h0) begin
      fails++;
      $display("FAIL abort got rdy=%b ov=%b busy=%b rnd=%0d ct=%h exp 1 0 0 0 0",
               in_ready, out_valid, busy, round, ciphertext);
    end
    drive_block(P2, K2, ct, lat);
    tests++;
    if (ct !== C2 || lat !== 11) begin
      fails++;
      $display("FAIL post_abort got %h lat=%0d exp %h lat=11", ct, lat, C2);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [127:0] outs [2];
    int acc_t [2];
    int nacc, nout, c;
    logic acc, outv;
    logic [127:0] cap;
    outs[0] = '0; outs[1] = '0;
    acc_t[0] = 0; acc_t[1] = 0;
    nacc = 0; nout = 0; c = 0;
    out_ready = 1;
    plaintext = P1;
    key = K1;
    in_valid = 1;
    while (nout < 2 && c < 60) begin
      acc = in_valid && in_ready;
      outv = out_valid && out_ready;
      cap = ciphertext;
      @(posedge clk); #1;
      c++;
      if (acc && nacc < 2) begin
        acc_t[nacc] = c;
        nacc++;
        if (nacc == 1) begin
          plaintext = P2;
          key = K2;
        end else begin
          in_valid = 0;
        end
      end
      if (outv) begin
        outs[nout] = cap;
        nout++;
      end
    end
    in_valid = 0;
    out_ready = 0;
    tests++;
    if (nout !== 2 || nacc !== 2) begin
      fails++;
      $display("FAIL b2b_count got outs=%0d accs=%0d exp 2 2", nout, nacc);
    end
    tests++;
    if (outs[0] !== C1) begin
      fails++;
      $display("FAIL b2b_ct1 got %h exp %h", outs[0], C1);
    end
    tests++;
    if (outs[1] !== C2) begin
      fails++;
      $display("FAIL b2b_ct2 got %h exp %h", outs[1], C2);
    end
    tests++;
    if (acc_t[1] - acc_t[0] !== 12) begin
      fails++;
      $display("FAIL b2b_gap got %0d exp 12", acc_t[1] - acc_t[0]);
    end
  endtask

  task automatic test_random();
    logic [127:0] p, k, ct, exp_ct;
    int lat;
    for (int i = 0; i < 8; i++) begin
      p = rnd128();
      k = rnd128();
      exp_ct = model_enc(p, k);
      drive_block(p, k, ct, lat);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      tests++;
      if (ct !== exp_ct || lat !== 11 || ciphertext !== exp_ct) begin
        fails++;
        $display("FAIL rand%0d got %h lat=%0d exp %h lat=11",
                 i, ct, lat, exp_ct);
      end
      release_out();
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rand_idle%0d got rdy=%b busy=%b exp 1 0",
                 i, in_ready, busy);
      end
    end
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    out_ready = 0;
    plaintext = '0;
    key = '0;
    build_sbox();
    test_reset();
    test_fips197();
    test_latency();
    test_hold();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge system clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have ports: in_valid input 1 (plaintext/key offered); in_ready output 1 (block can accept).
REQ-003 SHALL have ports: plaintext input 128 (state, byte 0 in bits [127:120], column-major); key input 128 (AES-128 cipher key, same byte order).
REQ-004 SHALL have ports: out_valid output 1 (ciphertext available); out_ready input 1 (consumer accepts); ciphertext output 128.
REQ-005 SHALL have ports: busy output 1 (encryption in progress); round output 4 (current round index 0..10, for debug/probe).
REQ-006 SHALL have no parameters; Nr = 10 is fixed.

Function
REQ-007 SHALL be an iterative AES-128 encryptor: one round per clk, sharing one SubBytes/ShiftRows/MixColumns/AddRoundKey datapath across all rounds.
REQ-008 SHALL use FSM states: IDLE, ROUND, DONE.
REQ-009 IDLE: in_ready=1; on in_valid=1, capture state<=plaintext^key, round_key<=key, round<=1, go to ROUND.
REQ-010 ROUND: each cycle, state<=AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), next_key) for round 1..9; for round 10, MixColumns is bypassed.
REQ-011 ROUND: each cycle, round_key<=next_key, where next_key = key-schedule step of round_key using Rcon[round] (01,02,04,08,10,20,40,80,1b,36).
REQ-012 ROUND: round increments by 1; after round 10 is written, go to DONE.
REQ-013 DONE: out_valid=1, ciphertext=state; hold both stable until out_ready=1; on out_valid&out_ready, go to IDLE in the same edge.
REQ-014 Latency: a handshake accepted at edge T SHALL give out_valid=1 from the cycle after edge T+10 (11 edges from acceptance to ciphertext).
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid in ROUND/DONE SHALL be ignored with no state change.
REQ-016 busy SHALL be 1 in ROUND and DONE and 0 in IDLE.
REQ-017 out_ready while out_valid=0 SHALL have no effect.
REQ-018 ciphertext SHALL be the live state register in all states; only its DONE value is meaningful.
REQ-019 round SHALL read 0 in IDLE, 1..10 in ROUND (the round being computed), and 10 in DONE.
REQ-020 DONE->IDLE and the next acceptance SHALL take at least one IDLE cycle; back-to-back throughput is 1 block per 12 cycles minimum.

Reset
REQ-021 rst=1 at a clk edge SHALL force IDLE, round=0, state=0, round_key=0, out_valid=0, in_ready=1 after that edge, taking priority over all other inputs.
REQ-022 rst mid-encryption (ROUND or DONE) SHALL abort the operation with no ciphertext produced; the next acceptance starts clean.

Structure
REQ-023 Shared package SHALL hold: FSM state encoding, Rcon table, NR=10 constant, S-box function.
REQ-024 Existing combinational SubBytes, ShiftRows, MixColumns and AddRoundKey modules SHALL be instantiated once each.
REQ-025 One sub-module aes_key_step SHALL be created: combinational (key_in, rcon) -> key_out, RotWord/SubWord/XOR chain.
REQ-026 Target size SHALL be 150-300 lines RTL, excluding reused modules.

Verification
REQ-027 Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ciphertext 3925841d02dc09fbdc118597196a0b32; in round 1, MixColumns input d4bf5d30e0b452aeb84111f11e2798e5 and output 046681e5e0cb199a48f8d37a2806264c.
REQ-028 Key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 edges after acceptance.
REQ-029 Hold out_ready=0 for 5 cycles in DONE -> out_valid and ciphertext stable; in_valid pulses meanwhile are ignored (in_ready=0).
REQ-030 Assert rst during round 5 -> next cycle IDLE, round=0, out_valid=0; then REQ-028 vector -> correct ciphertext.
REQ-031 Two back-to-back blocks (REQ-027 then REQ-028), out_ready tied 1 -> both ciphertexts correct, second accepted 12 cycles after first.
